// File: rtl/picc_pkg.sv
// Shared types and constants for the PICC load-modulation transmitter.
// Latency: none (declarations only).
// Backpressure: none.
//
// Contents: FSM state enum, bit-sequence enum, CRC_A constants, parity helper.
package picc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SOF    = 3'd1,
        DATA   = 3'd2,
        PAR    = 3'd3,
        CRC_LO = 3'd4,
        CRC_HI = 3'd5,
        EOF    = 3'd6
    } state_t;

    // D: subcarrier in first half, E: subcarrier in second half, F: no subcarrier
    typedef enum logic [1:0] {
        SEQ_D = 2'd0,
        SEQ_E = 2'd1,
        SEQ_F = 2'd2
    } seq_t;

    localparam logic [15:0] CRC_A_INIT = 16'h6363;
    localparam logic [15:0] CRC_A_POLY = 16'h8408;

    // Odd parity: parity bit makes the total count of ones odd
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/picc_crc_a.sv
// Byte-serial CRC_A (ISO14443A) accumulator, reflected polynomial 0x8408.
// Latency: result of a byte visible one cycle after en_in.
// Backpressure: none; one byte consumed per cycle with en_in high.
//
// Ports: clk_in/rst_in clock and async high reset; init_in reloads the preset,
// en_in folds byte_in into the CRC; crc_out is the registered CRC value.
module picc_crc_a
    import picc_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        init_in,
    input  logic        en_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_in) begin
            crc_d = CRC_A_INIT;
        end else if (en_in) begin
            crc_d = crc_q ^ {8'h00, byte_in};
            for (int i = 0; i < 8; i++) begin
                crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_A_POLY) : (crc_d >> 1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            crc_q <= CRC_A_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/picc_load_mod_tx.sv
// PICC-to-PCD ISO14443A Type A frame serialiser with fc/16 Manchester load modulation.
// Latency: busy/mod from the edge after the accepted trigger; amp_out 1 cycle after mod_out.
// Backpressure: triggers while busy are dropped; a trigger on the done_out cycle is accepted.
//
// Ports: clk_in/rst_in (async active-high), data_in/num_bytes_in payload and length,
// trigger_in start level, sine_in carrier in; busy_out, done_out pulse, mod_out, amp_out.
// Build option: define PICC_TX_CRC_EN to append CRC_A (low byte first) after the payload.
module picc_load_mod_tx
    import picc_pkg::*;
#(
    parameter int MAX_BYTES   = 8,
    parameter int BIT_CYC     = 1280,
    parameter int SUBC_HALF   = 80,
    parameter int AMP_W       = 16,
    parameter int DEPTH_SHIFT = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [8*MAX_BYTES-1:0]           data_in,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   num_bytes_in,
    input  logic                             trigger_in,
    input  logic signed [AMP_W-1:0]          sine_in,
    output logic                             busy_out,
    output logic                             done_out,
    output logic                             mod_out,
    output logic signed [AMP_W-1:0]          amp_out
);

    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int CW = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam int SW = (SUBC_HALF > 1) ? $clog2(SUBC_HALF) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYC / 2);
    localparam logic [SW-1:0] SUB_LAST = SW'(SUBC_HALF - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_BYTES);

    state_t                 state_q, state_d;
    logic [8*MAX_BYTES-1:0] buf_q, buf_d;
    logic [LW-1:0]          len_q, len_d;
    logic [LW-1:0]          byte_idx_q, byte_idx_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [SW-1:0]          sub_cnt_q, sub_cnt_d;
    logic                   sub_ph_q, sub_ph_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mod_q, mod_d;
    logic signed [AMP_W-1:0] amp_q, amp_d;

    logic       accept;
    logic       bit_end;
    logic [7:0] cur_byte;
    seq_t       seq;
    logic       half_on;

    function automatic logic [7:0] sel_byte(input logic [8*MAX_BYTES-1:0] b,
                                            input logic [LW-1:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx == LW'(k)) r = b[8*k +: 8];
        end
        return r;
    endfunction

    assign accept  = (state_q == IDLE) && trigger_in && (num_bytes_in != '0);
    assign bit_end = (cyc_q == CYC_LAST);

`ifdef PICC_TX_CRC_EN
    logic [15:0] crc_val;
    logic        crc_en;

    // Fold each payload byte in as its last data bit finishes; CRC is
    // settled well before the CRC_LO period starts.
    assign crc_en = (state_q == DATA) && bit_end && (bit_idx_q == 4'd7);

    picc_crc_a u_crc (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .init_in (accept),
        .en_in   (crc_en),
        .byte_in (sel_byte(buf_q, byte_idx_q)),
        .crc_out (crc_val)
    );
`endif

    // Frame sequencing: one step per completed bit period
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        cyc_d      = cyc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d    = SOF;
                buf_d      = data_in;
                len_d      = (num_bytes_in > LEN_MAX) ? LEN_MAX : num_bytes_in;
                byte_idx_d = '0;
                bit_idx_d  = '0;
                cyc_d      = '0;
                busy_d     = 1'b1;
            end
        end else if (!bit_end) begin
            cyc_d = cyc_q + 1'b1;
        end else begin
            cyc_d = '0;
            case (state_q)
                SOF: begin
                    state_d    = DATA;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
                DATA: begin
                    if (bit_idx_q == 4'd7) state_d = PAR;
                    else                   bit_idx_d = bit_idx_q + 4'd1;
                end
                PAR: begin
                    bit_idx_d = '0;
                    if (byte_idx_q == len_q - 1'b1) begin
`ifdef PICC_TX_CRC_EN
                        state_d = CRC_LO;
`else
                        state_d = EOF;
`endif
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = DATA;
                    end
                end
`ifdef PICC_TX_CRC_EN
                // CRC bytes use bit_idx 0..7 for data and 8 for parity
                CRC_LO: begin
                    if (bit_idx_q == 4'd8) begin
                        bit_idx_d = '0;
                        state_d   = CRC_HI;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
                CRC_HI: begin
                    if (bit_idx_q == 4'd8) begin
                        bit_idx_d = '0;
                        state_d   = EOF;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
`endif
                EOF: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Output coding is derived from next-state values so mod_out lines up
    // with the bit period that the registered state is entering.
    always_comb begin
        cur_byte = sel_byte(buf_d, byte_idx_d);
        case (state_d)
            SOF:  seq = SEQ_D;
            DATA: seq = cur_byte[bit_idx_d[2:0]] ? SEQ_D : SEQ_E;
            PAR:  seq = odd_par(cur_byte) ? SEQ_D : SEQ_E;
`ifdef PICC_TX_CRC_EN
            CRC_LO: begin
                if (bit_idx_d == 4'd8) seq = odd_par(crc_val[7:0]) ? SEQ_D : SEQ_E;
                else                   seq = crc_val[bit_idx_d[2:0]] ? SEQ_D : SEQ_E;
            end
            CRC_HI: begin
                if (bit_idx_d == 4'd8) seq = odd_par(crc_val[15:8]) ? SEQ_D : SEQ_E;
                else                   seq = crc_val[4'd8 + bit_idx_d] ? SEQ_D : SEQ_E;
            end
`endif
            default: seq = SEQ_F;
        endcase

        // Subcarrier restarts at each half so every modulated half begins high
        sub_cnt_d = sub_cnt_q;
        sub_ph_d  = sub_ph_q;
        if (cyc_d == '0 || cyc_d == CYC_HALF) begin
            sub_cnt_d = '0;
            sub_ph_d  = 1'b1;
        end else if (sub_cnt_q == SUB_LAST) begin
            sub_cnt_d = '0;
            sub_ph_d  = ~sub_ph_q;
        end else begin
            sub_cnt_d = sub_cnt_q + 1'b1;
        end

        case (seq)
            SEQ_D:   half_on = (cyc_d <  CYC_HALF);
            SEQ_E:   half_on = (cyc_d >= CYC_HALF);
            default: half_on = 1'b0;
        endcase
        mod_d = half_on & sub_ph_d;

        amp_d = mod_q ? (sine_in >>> DEPTH_SHIFT) : sine_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            cyc_q      <= '0;
            sub_cnt_q  <= '0;
            sub_ph_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mod_q      <= 1'b0;
            amp_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            cyc_q      <= cyc_d;
            sub_cnt_q  <= sub_cnt_d;
            sub_ph_q   <= sub_ph_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mod_q      <= mod_d;
            amp_q      <= amp_d;
        end
    end

    assign busy_out = busy_q;
    assign done_out = done_q;
    assign mod_out  = mod_q;
    assign amp_out  = amp_q;

endmodule
